// File: rtl/udp_ip_tx_framer.sv
// rtl/udp_ip_tx_framer.sv - UDP datagram framer feeding the IP transmit path
module udp_ip_tx_framer #(
  parameter logic [7:0] IP_TTL  = 8'd64,
  parameter logic [5:0] IP_DSCP = 6'd0,
  parameter logic [1:0] IP_ECN  = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [31:0] s_udp_source_ip,
  input  logic [31:0] s_udp_dest_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [15:0] s_udp_payload_len,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,
  output logic        m_ip_hdr_valid,
  input  logic        m_ip_hdr_ready,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [7:0]  m_ip_ttl,
  output logic [7:0]  m_ip_protocol,
  output logic [15:0] m_ip_length,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,
  output logic [7:0]  m_ip_payload_axis_tdata,
  output logic        m_ip_payload_axis_tvalid,
  input  logic        m_ip_payload_axis_tready,
  output logic        m_ip_payload_axis_tlast,
  output logic        m_ip_payload_axis_tuser,
  output logic        busy,
  output logic        error_early_termination,
  output logic        error_oversize
);

  localparam logic [15:0] MAX_LEN = 16'd65507;

  typedef enum logic [2:0] {IDLE, IP_HDR, UDP_HDR, PAYLOAD, DRAIN} state_t;

  state_t      state, state_next;
  logic [2:0]  hdr_idx;
  logic [15:0] count, payload_len, udp_len, src_port, dst_port;
  logic [7:0]  hdr_byte;
  logic        last_count, accept, oversize_set, early_set, hdr_xfer, pay_xfer;

  assign last_count     = (count == payload_len - 16'd1);
  assign busy           = (state != IDLE);
  assign m_ip_hdr_valid = (state == IP_HDR);
  assign m_ip_protocol  = 8'd17;
  assign m_ip_ttl       = IP_TTL;
  assign m_ip_dscp      = IP_DSCP;
  assign m_ip_ecn       = IP_ECN;

  // Header bytes come from latched fields indexed by a register, so they only move on transfer.
  always_comb begin
    case (hdr_idx)
      3'd0:    hdr_byte = src_port[15:8];
      3'd1:    hdr_byte = src_port[7:0];
      3'd2:    hdr_byte = dst_port[15:8];
      3'd3:    hdr_byte = dst_port[7:0];
      3'd4:    hdr_byte = udp_len[15:8];
      3'd5:    hdr_byte = udp_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next                = state;
    s_udp_hdr_ready           = 1'b0;
    s_udp_payload_axis_tready = 1'b0;
    m_ip_payload_axis_tdata   = 8'h00;
    m_ip_payload_axis_tvalid  = 1'b0;
    m_ip_payload_axis_tlast   = 1'b0;
    m_ip_payload_axis_tuser   = 1'b0;
    accept                    = 1'b0;
    oversize_set              = 1'b0;
    early_set                 = 1'b0;
    hdr_xfer                  = 1'b0;
    pay_xfer                  = 1'b0;
    case (state)
      IDLE: begin
        s_udp_hdr_ready = 1'b1;
        if (s_udp_hdr_valid) begin
          if (s_udp_payload_len > MAX_LEN) begin
            oversize_set = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = IP_HDR;
          end
        end
      end
      IP_HDR: begin
        if (m_ip_hdr_ready) state_next = UDP_HDR;
      end
      UDP_HDR: begin
        m_ip_payload_axis_tdata  = hdr_byte;
        m_ip_payload_axis_tvalid = 1'b1;
        m_ip_payload_axis_tlast  = (hdr_idx == 3'd7) && (payload_len == 16'd0);
        if (m_ip_payload_axis_tready) begin
          hdr_xfer = 1'b1;
          if (hdr_idx == 3'd7) state_next = (payload_len == 16'd0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        m_ip_payload_axis_tdata   = s_udp_payload_axis_tdata;
        m_ip_payload_axis_tvalid  = s_udp_payload_axis_tvalid;
        s_udp_payload_axis_tready = m_ip_payload_axis_tready;
        m_ip_payload_axis_tlast   = s_udp_payload_axis_tlast || last_count;
        // A length mismatch in either direction marks the final beat bad.
        m_ip_payload_axis_tuser   = s_udp_payload_axis_tuser ||
                                    (s_udp_payload_axis_tlast != last_count);
        if (s_udp_payload_axis_tvalid && m_ip_payload_axis_tready) begin
          pay_xfer = 1'b1;
          if (s_udp_payload_axis_tlast) begin
            early_set  = !last_count;
            state_next = IDLE;
          end else if (last_count) begin
            early_set  = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_udp_payload_axis_tready = 1'b1;
        if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_oversize          <= 1'b0;
      error_early_termination <= 1'b0;
      m_ip_length             <= 16'd0;
      m_ip_source_ip          <= 32'd0;
      m_ip_dest_ip            <= 32'd0;
      src_port                <= 16'd0;
      dst_port                <= 16'd0;
      udp_len                 <= 16'd0;
      payload_len             <= 16'd0;
      hdr_idx                 <= 3'd0;
      count                   <= 16'd0;
    end else begin
      error_oversize          <= oversize_set;
      error_early_termination <= early_set;
      if (accept) begin
        m_ip_length    <= s_udp_payload_len + 16'd28;
        udp_len        <= s_udp_payload_len + 16'd8;
        payload_len    <= s_udp_payload_len;
        m_ip_source_ip <= s_udp_source_ip;
        m_ip_dest_ip   <= s_udp_dest_ip;
        src_port       <= s_udp_source_port;
        dst_port       <= s_udp_dest_port;
      end
      if (state == IP_HDR)  hdr_idx <= 3'd0;
      else if (hdr_xfer)    hdr_idx <= hdr_idx + 3'd1;
      if (state == UDP_HDR) count <= 16'd0;
      else if (pay_xfer)    count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_ip_tx_framer.sv
// tb/tb_udp_ip_tx_framer.sv - table-driven and randomized bench for udp_ip_tx_framer
module tb_udp_ip_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_udp_hdr_valid, s_udp_hdr_ready;
  logic [31:0] s_udp_source_ip, s_udp_dest_ip;
  logic [15:0] s_udp_source_port, s_udp_dest_port, s_udp_payload_len;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic        m_ip_hdr_valid, m_ip_hdr_ready;
  logic [5:0]  m_ip_dscp;
  logic [1:0]  m_ip_ecn;
  logic [7:0]  m_ip_ttl, m_ip_protocol;
  logic [15:0] m_ip_length;
  logic [31:0] m_ip_source_ip, m_ip_dest_ip;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic        busy, error_early_termination, error_oversize;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udp_ip_tx_framer dut (
    .clk(clk), .rst_n(rst_n),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_source_ip(s_udp_source_ip), .s_udp_dest_ip(s_udp_dest_ip),
    .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
    .s_udp_payload_len(s_udp_payload_len),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tready(s_tready), .s_udp_payload_axis_tlast(s_tlast),
    .s_udp_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
    .m_ip_protocol(m_ip_protocol), .m_ip_length(m_ip_length),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tvalid(m_tvalid),
    .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(m_tlast),
    .m_ip_payload_axis_tuser(m_tuser),
    .busy(busy), .error_early_termination(error_early_termination),
    .error_oversize(error_oversize)
  );

  typedef struct {
    logic [15:0] sp, dp;
    logic [31:0] sip, dip;
    logic [15:0] len;
    int          n;          // source bytes offered, tlast on the last one
    int          tr_mode;    // 0 always ready, 1 toggling, 2 random
    int          hdr_delay;
    bit          rnd;        // random payload/tuser, else AA BB CC ...
    int          abort_after;
    logic [15:0] exp_len;
  } vec_t;

  typedef logic [9:0] beat_t;  // {data, last, user}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_packet(input vec_t v);
    logic [7:0] sd[$];
    bit         su[$];
    beat_t      expq[$], outq[$];
    logic [15:0] ulen;
    int   src_idx = 0, cyc = 0, hv_cnt = 0, early = 0, ovs = 0, out_n, budget;
    bit   started = 0, done = 0, aborted = 0, hdr_checked = 0, stalled = 0;
    bit   hdr_acc, src_x;
    beat_t held = '0;

    for (int k = 0; k < v.n; k++) begin
      sd.push_back(v.rnd ? 8'($urandom) : 8'(8'hAA + 8'(k * 17)));
      su.push_back(v.rnd && ($urandom_range(0, 7) == 0));
    end
    // Reference: 8-byte UDP header, then the first min(n,len) source bytes;
    // the stream ends on its final beat, flagged bad when the lengths differ.
    ulen = v.len + 16'd8;
    expq.push_back({v.sp[15:8], 2'b00});
    expq.push_back({v.sp[7:0], 2'b00});
    expq.push_back({v.dp[15:8], 2'b00});
    expq.push_back({v.dp[7:0], 2'b00});
    expq.push_back({ulen[15:8], 2'b00});
    expq.push_back({ulen[7:0], 2'b00});
    expq.push_back({8'h00, 2'b00});
    expq.push_back({8'h00, v.len == 16'd0, 1'b0});
    out_n = (v.n < int'(v.len)) ? v.n : int'(v.len);
    for (int k = 0; k < out_n; k++)
      expq.push_back({sd[k], k == out_n - 1, su[k] || (k == out_n - 1 && v.n != int'(v.len))});
    budget = 300 + 4 * (v.n + 8);

    @(negedge clk);
    s_udp_hdr_valid   = 1'b1;
    s_udp_source_port = v.sp;
    s_udp_dest_port   = v.dp;
    s_udp_source_ip   = v.sip;
    s_udp_dest_ip     = v.dip;
    s_udp_payload_len = v.len;
    s_tvalid          = 1'b0;
    m_tready          = (v.tr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    m_ip_hdr_ready    = (v.hdr_delay == 0);

    while (!done) begin
      #1;
      hdr_acc = s_udp_hdr_valid && s_udp_hdr_ready;
      if (m_ip_hdr_valid) begin
        if (!hdr_checked) begin
          check("ip_length", m_ip_length, v.exp_len);
          check("ip_protocol", m_ip_protocol, 8'h11);
          check("ip_ttl", m_ip_ttl, 8'd64);
          check("ip_dscp_ecn", {m_ip_dscp, m_ip_ecn}, 8'h00);
          check("ip_src", m_ip_source_ip, v.sip);
          check("ip_dst", m_ip_dest_ip, v.dip);
          hdr_checked = 1;
        end
        hv_cnt++;
      end
      if (stalled) check("stall_hold", {m_tvalid, m_tdata, m_tlast}, {1'b1, held[9:1]});
      stalled = m_tvalid && !m_tready;
      if (stalled) held = {m_tdata, m_tlast, m_tuser};
      if (m_tvalid && m_tready) outq.push_back({m_tdata, m_tlast, m_tuser});
      src_x = s_tvalid && s_tready;
      if (busy) started = 1;
      if (error_early_termination) early++;
      if (error_oversize) ovs++;
      if (v.abort_after >= 0 && outq.size() == v.abort_after) begin
        rst_n = 1'b0;
        #1;
        check("rst_valids", {m_ip_hdr_valid, m_tvalid}, 2'b00);
        check("rst_busy_err", {busy, error_early_termination, error_oversize}, 3'b000);
        s_tvalid = 1'b0;
        s_udp_hdr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        done = 1;
      end else if (started && !busy && src_idx == v.n) begin
        done = 1;
      end else if (cyc > budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: packet len %0d got %0d beats expected %0d", v.len, outq.size(), expq.size());
        done = 1;
        aborted = 1;
      end else begin
        @(negedge clk);
        cyc++;
        if (hdr_acc) s_udp_hdr_valid = 1'b0;
        if (src_x) src_idx++;
        if (!s_tvalid || src_x) begin
          if (src_idx < v.n && (v.tr_mode == 0 || $urandom_range(0, 3) != 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = sd[src_idx];
            s_tlast  = (src_idx == v.n - 1);
            s_tuser  = su[src_idx];
          end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
          end
        end
        case (v.tr_mode)
          0:       m_tready = 1'b1;
          1:       m_tready = ~m_tready;
          default: m_tready = 1'($urandom_range(0, 1));
        endcase
        m_ip_hdr_ready = (hv_cnt >= v.hdr_delay);
      end
    end
    s_tvalid = 1'b0;

    if (!aborted) begin
      check("beat_count", outq.size(), expq.size());
      check("early_pulses", early, (v.len != 0 && v.n != int'(v.len)) ? 1 : 0);
      check("oversize_quiet", ovs, 0);
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++)
      check($sformatf("beat%0d{data,last,user}", i), outq[i], expq[i]);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   ovs_cnt, hv_seen, bz_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1234, 16'h5678, 32'h0A000001, 32'hC0A8010A, 16'd4, 4, 0, 0, 1'b0, -1, 16'h0020};
    tbl[1] = '{16'h1234, 16'h5678, 32'h0A000001, 32'hC0A8010A, 16'd4, 4, 1, 5, 1'b0, -1, 16'h0020};
    tbl[2] = '{16'h0400, 16'h0035, 32'h01020304, 32'h05060708, 16'd6, 3, 2, 1, 1'b1, -1, 16'h0022};
    tbl[3] = '{16'hBEEF, 16'h0007, 32'hAC100001, 32'hAC100002, 16'd2, 5, 0, 0, 1'b1, -1, 16'h001E};
    tbl[4] = '{16'h0001, 16'h0002, 32'h7F000001, 32'h7F000002, 16'd0, 0, 1, 2, 1'b0, -1, 16'd28};
    tbl[5] = '{16'hFFFF, 16'h8000, 32'hFFFFFFFF, 32'h00000000, 16'd65507, 16, 0, 0, 1'b1, 8, 16'hFFFF};
    tbl[6] = '{16'h1111, 16'h2222, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'd20, 20, 0, 0, 1'b1, 12, 16'h0030};
    tbl[7] = '{16'h3333, 16'h4444, 32'hC0000201, 32'hC0000202, 16'd5, 5, 2, 3, 1'b1, -1, 16'h0021};

    rst_n = 1'b0;
    s_udp_hdr_valid = 1'b0;
    s_udp_source_ip = '0; s_udp_dest_ip = '0;
    s_udp_source_port = '0; s_udp_dest_port = '0; s_udp_payload_len = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_ip_hdr_ready = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valids", {m_ip_hdr_valid, m_tvalid}, 2'b00);
    check("reset_busy_err", {busy, error_early_termination, error_oversize}, 3'b000);
    check("reset_hdr_ready", s_udp_hdr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_packet(tbl[t]);

    // Oversize request: one error pulse, nothing produced, back to accepting.
    @(negedge clk);
    s_udp_hdr_valid   = 1'b1;
    s_udp_payload_len = 16'd65508;
    #1;
    check("oversize_hdr_ready", s_udp_hdr_ready, 1'b1);
    ovs_cnt = 0; hv_seen = 0; bz_seen = 0;
    @(negedge clk);
    s_udp_hdr_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (error_oversize) ovs_cnt++;
      if (m_ip_hdr_valid) hv_seen++;
      if (busy) bz_seen++;
      @(negedge clk);
    end
    check("oversize_pulses", ovs_cnt, 1);
    check("oversize_no_hdr", hv_seen, 0);
    check("oversize_not_busy", bz_seen, 0);

    for (int r = 0; r < 10; r++) begin
      rv.sp = 16'($urandom); rv.dp = 16'($urandom);
      rv.sip = $urandom; rv.dip = $urandom;
      rv.len = 16'($urandom_range(0, 40));
      if (rv.len == 16'd0) rv.n = 0;
      else if ($urandom_range(0, 1) == 1) rv.n = int'(rv.len);
      else rv.n = $urandom_range(1, int'(rv.len) + 4);
      rv.tr_mode = $urandom_range(0, 2);
      rv.hdr_delay = $urandom_range(0, 3);
      rv.rnd = 1'b1;
      rv.abort_after = -1;
      rv.exp_len = rv.len + 16'd28;
      run_packet(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
